// File: rtl/pmt_bin_counter.sv
// Multi-channel PMT edge counter: synchronised inputs, back-to-back time bins,
// and a single-entry valid/ready result register with sticky overflow.
//
// state | meaning
// IDLE  | waiting for a start with non-zero bin length and bin count
// RUN   | counting edges; one result transfer at the end of every bin
module pmt_bin_counter #(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 16,
   parameter int BIN_W       = 24,
   parameter int NB_W        = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         pmt_in,
   input  logic [BIN_W-1:0]        bin_len,
   input  logic [NB_W-1:0]         num_bins,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [N_CH*CNT_W-1:0]   cnt_data,
   output logic [NB_W-1:0]         cnt_bin,
   output logic [N_CH-1:0]         cnt_sat,
   output logic                    cnt_valid,
   input  logic                    cnt_ready,
   output logic                    overflow
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                           state;
   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
   logic [N_CH-1:0]                  prev_q;
   logic [N_CH-1:0]                  edge_q;
   logic [N_CH-1:0][CNT_W-1:0]       acc_q;
   logic [N_CH-1:0][CNT_W-1:0]       acc_nxt;
   logic [N_CH-1:0]                  sat_q;
   logic [N_CH-1:0]                  sat_nxt;
   logic [BIN_W-1:0]                 tick_q;
   logic [BIN_W-1:0]                 bin_len_q;
   logic [NB_W-1:0]                  bin_idx_q;
   logic [NB_W-1:0]                  num_bins_q;
   logic                             start_ok;
   logic                             bin_end;
   logic                             last_bin;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= '0;
         edge_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pmt_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   // Saturating add; sat flags a channel that lost an edge at full scale.
   always_comb begin
      acc_nxt = acc_q;
      sat_nxt = sat_q;
      for (int c = 0; c < N_CH; c++) begin
         if (edge_q[c]) begin
            if (&acc_q[c]) sat_nxt[c] = 1'b1;
            else           acc_nxt[c] = acc_q[c] + CNT_W'(1);
         end
      end
   end

   assign start_ok = (state == IDLE) && start && (bin_len != '0) && (num_bins != '0);
   assign bin_end  = (state == RUN) && (tick_q == bin_len_q - BIN_W'(1));
   assign last_bin = (bin_idx_q == num_bins_q - NB_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         acc_q      <= '0;
         sat_q      <= '0;
         tick_q     <= '0;
         bin_idx_q  <= '0;
         bin_len_q  <= '0;
         num_bins_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  bin_len_q  <= bin_len;
                  num_bins_q <= num_bins;
                  acc_q      <= '0;
                  sat_q      <= '0;
                  tick_q     <= '0;
                  bin_idx_q  <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (bin_end) begin
                  // This cycle's edges leave with the result; next bin starts clean.
                  acc_q  <= '0;
                  sat_q  <= '0;
                  tick_q <= '0;
                  if (last_bin) begin
                     bin_idx_q <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     bin_idx_q <= bin_idx_q + NB_W'(1);
                  end
               end else begin
                  acc_q  <= acc_nxt;
                  sat_q  <= sat_nxt;
                  tick_q <= tick_q + BIN_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_data  <= '0;
         cnt_bin   <= '0;
         cnt_sat   <= '0;
         cnt_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (start_ok) overflow <= 1'b0;
         if (bin_end) begin
            if (!cnt_valid || cnt_ready) begin
               cnt_data  <= acc_nxt;
               cnt_bin   <= bin_idx_q;
               cnt_sat   <= sat_nxt;
               cnt_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (cnt_valid && cnt_ready) begin
            cnt_valid <= 1'b0;
         end
      end
   end

endmodule
